// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add sequencer.
//   stateE : sequencer FSM states (idle, byte-serial run, done pulse)
//   BYTE_W : width of the add slice, in bits
//   clog2  : index width for a byte counter covering n bytes
package mp_add_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } stateE;

  // Never returns 0, so a one-byte operand still gets a 1-bit index.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_add_slice.sv
// Combinational 8-bit adder slice with carry in and carry out.
//   addA, addB : operand bytes
//   carryIn    : carry into bit 0
//   sum        : 8-bit sum
//   carryOut   : carry out of bit 7
module byte_add_slice
  import mp_add_pkg::*;
(
  input  logic [BYTE_W-1:0] addA,
  input  logic [BYTE_W-1:0] addB,
  input  logic              carryIn,
  output logic [BYTE_W-1:0] sum,
  output logic              carryOut
);

  always_comb begin
    {carryOut, sum} = {1'b0, addA} + {1'b0, addB} + {{BYTE_W{1'b0}}, carryIn};
  end

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add controller: adds two WORDS-byte operands through one 8-bit slice,
// LSB byte first, carrying between cycles in a register.
// Optional feature macro: SUB_EN (adds RCOSubMode and X-Y with borrow convention).
//   RCOClk, RCOReset      : clock, synchronous active-high reset
//   RCOStart              : start request, honoured only while RCOReady=1
//   RCOAddX, RCOAddY      : operands, captured on accepted start
//   RCOCarryIn            : initial carry (borrow-in when subtracting)
//   RCOSubMode            : SUB_EN only, 1 selects X-Y
//   RCOReady, RCOBusy     : idle/accepting, processing bytes
//   RCODone               : one-cycle result-valid pulse
//   RCOSum, RCOCarryOut   : result and final carry, held until the next accepted start
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                    RCOClk,
  input  logic                    RCOReset,
  input  logic                    RCOStart,
  input  logic [BYTE_W*WORDS-1:0] RCOAddX,
  input  logic [BYTE_W*WORDS-1:0] RCOAddY,
  input  logic                    RCOCarryIn,
`ifdef SUB_EN
  input  logic                    RCOSubMode,
`endif
  output logic                    RCOReady,
  output logic                    RCOBusy,
  output logic                    RCODone,
  output logic [BYTE_W*WORDS-1:0] RCOSum,
  output logic                    RCOCarryOut
);

  localparam int unsigned OpW  = BYTE_W * WORDS;
  localparam int unsigned IdxW = clog2(WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  stateE           stateQ;
  logic [OpW-1:0]  xQ;
  logic [OpW-1:0]  yQ;
  logic            carryQ;
  logic [IdxW-1:0] indexQ;
`ifdef SUB_EN
  logic            subQ;
`endif

  logic [BYTE_W-1:0] xByte;
  logic [BYTE_W-1:0] yByte;
  logic [BYTE_W-1:0] sliceSum;
  logic              sliceCarry;

  always_comb begin
    xByte = xQ[indexQ*BYTE_W +: BYTE_W];
`ifdef SUB_EN
    // X + ~Y + ~borrowIn == X - Y - borrowIn; final carry reads as NOT borrow.
    yByte = subQ ? ~yQ[indexQ*BYTE_W +: BYTE_W] : yQ[indexQ*BYTE_W +: BYTE_W];
`else
    yByte = yQ[indexQ*BYTE_W +: BYTE_W];
`endif
  end

  byte_add_slice uSlice (
    .addA     (xByte),
    .addB     (yByte),
    .carryIn  (carryQ),
    .sum      (sliceSum),
    .carryOut (sliceCarry)
  );

  always_ff @(posedge RCOClk) begin
    if (RCOReset) begin
      stateQ      <= StIdle;
      xQ          <= '0;
      yQ          <= '0;
      carryQ      <= 1'b0;
      indexQ      <= '0;
`ifdef SUB_EN
      subQ        <= 1'b0;
`endif
      RCOReady    <= 1'b1;
      RCOBusy     <= 1'b0;
      RCODone     <= 1'b0;
      RCOSum      <= '0;
      RCOCarryOut <= 1'b0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          RCODone <= 1'b0;
          if (RCOStart) begin
            xQ       <= RCOAddX;
            yQ       <= RCOAddY;
            indexQ   <= '0;
`ifdef SUB_EN
            subQ     <= RCOSubMode;
            carryQ   <= RCOSubMode ? ~RCOCarryIn : RCOCarryIn;
`else
            carryQ   <= RCOCarryIn;
`endif
            RCOReady <= 1'b0;
            RCOBusy  <= 1'b1;
            stateQ   <= StRun;
          end
        end
        StRun: begin
          // Result is built in place; bytes above indexQ still hold the previous result.
          RCOSum[indexQ*BYTE_W +: BYTE_W] <= sliceSum;
          carryQ <= sliceCarry;
          if (indexQ == LastIdx) begin
            RCOBusy <= 1'b0;
            stateQ  <= StDone;
          end else begin
            indexQ <= indexQ + 1'b1;
          end
        end
        StDone: begin
          RCODone     <= 1'b1;
          RCOCarryOut <= carryQ;
          RCOReady    <= 1'b1;
          stateQ      <= StIdle;
        end
        default: begin
          stateQ <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Scoreboard bench for mp_add_sequencer (WORDS=4): accepted starts push expected results and
// completion cycles; a negedge monitor pops and compares on every RCODone.
module tb_mp_add_sequencer;

  localparam int unsigned WORDS = 4;
  localparam int unsigned OPW   = 8 * WORDS;

  logic           clk;
  logic           rst;
  logic           start;
  logic [OPW-1:0] addX;
  logic [OPW-1:0] addY;
  logic           cin;
  logic           mode;
  logic           ready;
  logic           busy;
  logic           done;
  logic [OPW-1:0] sum;
  logic           cout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference-model bookkeeping, all from bench-side stimulus.
  int  nextFree   = 0;
  int  lastAccept = 0;
  bit  hasOp      = 0;
  bit  monOn      = 0;
  logic prevDone  = 1'b0;
  logic [OPW:0] expQ[$];
  int           expCycQ[$];

  mp_add_sequencer #(.WORDS(WORDS)) dut (
    .RCOClk      (clk),
    .RCOReset    (rst),
    .RCOStart    (start),
    .RCOAddX     (addX),
    .RCOAddY     (addY),
    .RCOCarryIn  (cin),
`ifdef SUB_EN
    .RCOSubMode  (mode),
`endif
    .RCOReady    (ready),
    .RCOBusy     (busy),
    .RCODone     (done),
    .RCOSum      (sum),
    .RCOCarryOut (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Full-width arithmetic: {carryOut, sum}.
  function automatic logic [OPW:0] refResult(input logic [OPW-1:0] x, input logic [OPW-1:0] y,
                                             input logic c, input logic m);
    logic [OPW:0] full;
    if (m) begin
      full = {1'b0, x} - {1'b0, y} - {{OPW{1'b0}}, c};
      return {~full[OPW], full[OPW-1:0]};
    end
    full = {1'b0, x} + {1'b0, y} + {{OPW{1'b0}}, c};
    return full;
  endfunction

  // Acceptance observer: the model decides whether a start is taken.
  always @(posedge clk) begin
    logic m;
`ifdef SUB_EN
    m = mode;
`else
    m = 1'b0;
`endif
    if (rst) begin
      expQ.delete();
      expCycQ.delete();
      hasOp    = 0;
      nextFree = cyc + 1;
    end else if (start && cyc >= nextFree) begin
      expQ.push_back(refResult(addX, addY, cin, m));
      expCycQ.push_back(cyc + WORDS + 2);
      lastAccept = cyc;
      hasOp      = 1;
      nextFree   = cyc + WORDS + 2;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (monOn && !rst) begin
      check("ready", 64'(ready), 64'(cyc >= nextFree));
      check("busy", 64'(busy), 64'(hasOp && cyc > lastAccept && cyc <= lastAccept + WORDS));
      if (done) begin
        check("done_width", 64'(prevDone), 64'd0);
        if (expQ.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          check("done_cycle", 64'(cyc), 64'(expCycQ[0]));
          check("sum", 64'(sum), 64'(expQ[0][OPW-1:0]));
          check("carry_out", 64'(cout), 64'(expQ[0][OPW]));
          void'(expQ.pop_front());
          void'(expCycQ.pop_front());
        end
      end else if (expCycQ.size() > 0 && cyc > expCycQ[0]) begin
        check("missing_done", 64'(done), 64'd1);
        void'(expQ.pop_front());
        void'(expCycQ.pop_front());
      end
    end
    prevDone = done;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic waitFree();
    while (cyc < nextFree) tick();
  endtask

  task automatic issue(input logic [OPW-1:0] x, input logic [OPW-1:0] y, input logic c,
                       input logic m);
    waitFree();
    addX  = x;
    addY  = y;
    cin   = c;
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; addX = '0; addY = '0; cin = 1'b0; mode = 1'b0;
    tick();
    tick();
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    tick();
    monOn = 1;

    // Ripple through three bytes, then full wrap.
    issue(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
`ifdef SUB_EN
    issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    issue(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
`endif

    // Reset mid-run: aborts, no result.
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    tick();

    // Start pulsed while busy is ignored.
    issue(32'hA5A5_0F0F, 32'h0101_F0F1, 1'b0, 1'b0);
    tick();
    addX = 32'hDEAD_BEEF; addY = 32'h1234_5678; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();

    // Start held high: one op every WORDS+2 cycles, operands changing every cycle.
    waitFree();
    start = 1'b1;
    for (int i = 0; i < 4 * (WORDS + 2); i++) begin
      addX = $urandom;
      addY = $urandom;
      cin  = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;

    // Random traffic with random idle gaps.
    for (int i = 0; i < 30; i++) begin
      logic m;
`ifdef SUB_EN
      m = 1'($urandom_range(0, 1));
`else
      m = 1'b0;
`endif
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), m);
      repeat ($urandom_range(0, 3)) tick();
    end

    for (int i = 0; i < 40 && expQ.size() > 0; i++) tick();
    check("drain", 64'(expQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
